rotate_sequencer: RTL and testbench
===================================

# rotate_sequencer

Batch controller that sits directly upstream of the CORDIC rotator. It holds up to NUM_POINTS signed integer vertices and, on one `i_go`, rotates every stored vertex by a common angle. It does this by issuing one start/done transaction per point to the rotator and writing each rotated result into a result bank. Downstream display logic reads results by index.

## Interface
- VEC_WIDTH, 7: vertex coordinate width, signed integer; must match the rotator.
- ANG_WIDTH, 9: angle width, signed degrees −180..180; must match the rotator.
- NUM_POINTS, 8: vertex/result bank depth.
- IDX_WIDTH, $clog2(NUM_POINTS): index width.
- TIMEOUT, 32: maximum cycles spent in WAIT before abort.

Ports:
- Clock and reset: `i_clk` is the clock; `i_rst_n` is the reset, asynchronous, active-low.
- `i_wr_en`, in, 1: write vertex `i_wr_idx`; ignored while `o_busy`.
- `i_wr_idx`, in, IDX_WIDTH: vertex write index.
- `i_wr_x` / `i_wr_y`, in, VEC_WIDTH each: vertex coordinates.
- `i_count`, in, IDX_WIDTH+1: number of points to rotate, sampled with `i_go`; clamped to NUM_POINTS.
- `i_angle`, in, ANG_WIDTH: rotation angle, sampled with `i_go`.
- `i_go`, in, 1: start a batch; ignored while `o_busy`.
- `o_busy`, out, 1: batch in progress.
- `o_done`, out, 1: one-cycle pulse at batch end.
- `o_error`, out, 1: sticky timeout flag; cleared by the next accepted `i_go`.
- `i_rd_idx`, in, IDX_WIDTH: result read index.
- `o_rd_x` / `o_rd_y`, out, VEC_WIDTH each: combinational read of the result bank.
- `o_rot_start`, out, 1: start pulse to the rotator.
- `o_rot_x` / `o_rot_y` / `o_rot_angle`, out: operands driven to the rotator.
- `i_rot_x` / `i_rot_y` / `i_rot_done`, in: rotator results and done pulse.

## Operation
- FSM states are IDLE, ISSUE, WAIT and FINISH.
- **IDLE**
  - On `i_go`: latch the angle into `ang_r`, latch the clamped count into `cnt_r`, clear `idx_r` and `o_error`.
  - If `cnt_r` is 0, go to FINISH; otherwise go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `o_rot_start`=1, `o_rot_x/y` = vertex[`idx_r`].
  - Clear the timeout counter; go to WAIT.
- **WAIT**
  - `o_rot_start`=0.
  - On `i_rot_done`: write `i_rot_x/i_rot_y` to result[`idx_r`]. If `idx_r`==`cnt_r`−1, go to FINISH; otherwise increment `idx_r` and go to ISSUE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT−1 without done: set `o_error`, go to IDLE, no `o_done`.
- **FINISH**: `o_done`=1 for one cycle, then go to IDLE.
- Operand holding:
  - `o_rot_angle` = `ang_r` continuously from ISSUE through the done cycle, because the rotator's output flip depends on the live angle.
  - `o_rot_x/y` stay stable from ISSUE through the done cycle.
- `o_busy` = state ≠ IDLE.
- Results of unprocessed indices retain their old values.
- `i_rot_done` outside WAIT is ignored.
- `i_wr_en` in IDLE on the same cycle as `i_go`: the write is performed, but the batch uses the updated vertex only if its index is processed after that cycle. Writing takes effect at the clock edge, so it is always visible.
- Async reset clears the FSM to IDLE, all counters, the vertex and result banks to 0, and all outputs to 0. Reset mid-batch aborts with no `o_done`.

## Timing
- `i_go` is sampled at cycle 0; ISSUE for point 0 is at cycle 1.
- The rotator (ITERATIONS=12) returns done 13 cycles after its start, so the point period is 14 cycles.
- The last done falls at 1+14·(N−1)+13; `o_done` asserts the cycle after.
- N=8 gives `o_done` at cycle 113. N=0 gives `o_done` at cycle 1.
- The timeout abort happens TIMEOUT cycles after ISSUE.
- The result bank is readable the cycle after the done edge.

## Structure
- Package `rotate_seq_pkg`:
  - state enum `seq_state_t`;
  - default widths VEC_WIDTH/ANG_WIDTH;
  - `ROT_LATENCY` = ITERATIONS+1.
- Sub-module `point_bank`: a NUM_POINTS × 2·VEC_WIDTH register file with one synchronous write port, one combinational read port and async clear.
- Instantiate it twice, once for vertices (read index `idx_r`) and once for results (read index `i_rd_idx`).

## Test plan
- Write vertex 0 = (50,0), `i_count`=1, angle 90, with the real rotator attached → `o_done` at cycle 15; result 0 = (0,50) ±1.
- Vertices (50,0), (0,50), (−30,40), angle 180, N=3 → results (−50,0), (0,−50), (30,−40) ±1; `o_done` at cycle 43.
- `i_count`=0 → `o_done` at cycle 1; no `o_rot_start`; results unchanged.
- Stub rotator that never returns done → `o_error`=1 and `o_busy`=0 at cycle 33. Next `i_go` clears `o_error`.
- Pulse `i_go` and `i_wr_en` while busy → both ignored; vertex bank unchanged; batch timing unchanged.
- Assert `i_rst_n`=0 mid-WAIT → all outputs 0 immediately. Later `i_rot_done` is ignored; no `o_done`.

Source files
------------

// File: rtl/rotate_seq_pkg.sv
// rotate_seq_pkg: shared widths, rotator latency and sequencer state encoding
package rotate_seq_pkg;
    localparam int VEC_WIDTH   = 7;
    localparam int ANG_WIDTH   = 9;
    localparam int ITERATIONS  = 12;
    localparam int ROT_LATENCY = ITERATIONS + 1;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} seq_state_t;
endpackage

// File: rtl/point_bank.sv
// point_bank: NUM_POINTS x (x,y) register file, one sync write port, one comb read port, async clear
module point_bank
    import rotate_seq_pkg::*;
#(
    parameter int VEC_WIDTH  = rotate_seq_pkg::VEC_WIDTH,
    parameter int NUM_POINTS = 8,
    parameter int IDX_WIDTH  = $clog2(NUM_POINTS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [IDX_WIDTH-1:0] i_wr_idx,
    input  logic [VEC_WIDTH-1:0] i_wr_x,
    input  logic [VEC_WIDTH-1:0] i_wr_y,
    input  logic [IDX_WIDTH-1:0] i_rd_idx,
    output logic [VEC_WIDTH-1:0] o_rd_x,
    output logic [VEC_WIDTH-1:0] o_rd_y
);
    logic [2*VEC_WIDTH-1:0] r_mem [NUM_POINTS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_mem <= '{default: '0};
        else if (i_wr_en)
            r_mem[i_wr_idx] <= {i_wr_x, i_wr_y};
    end

    assign {o_rd_x, o_rd_y} = r_mem[i_rd_idx];
endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: rotates a bank of stored vertices by one angle, one rotator transaction per point
module rotate_sequencer
    import rotate_seq_pkg::*;
#(
    parameter int VEC_WIDTH  = rotate_seq_pkg::VEC_WIDTH,
    parameter int ANG_WIDTH  = rotate_seq_pkg::ANG_WIDTH,
    parameter int NUM_POINTS = 8,
    parameter int IDX_WIDTH  = $clog2(NUM_POINTS),
    parameter int TIMEOUT    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [IDX_WIDTH-1:0] i_wr_idx,
    input  logic [VEC_WIDTH-1:0] i_wr_x,
    input  logic [VEC_WIDTH-1:0] i_wr_y,
    input  logic [IDX_WIDTH:0]   i_count,
    input  logic [ANG_WIDTH-1:0] i_angle,
    input  logic                 i_go,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    input  logic [IDX_WIDTH-1:0] i_rd_idx,
    output logic [VEC_WIDTH-1:0] o_rd_x,
    output logic [VEC_WIDTH-1:0] o_rd_y,
    output logic                 o_rot_start,
    output logic [VEC_WIDTH-1:0] o_rot_x,
    output logic [VEC_WIDTH-1:0] o_rot_y,
    output logic [ANG_WIDTH-1:0] o_rot_angle,
    input  logic [VEC_WIDTH-1:0] i_rot_x,
    input  logic [VEC_WIDTH-1:0] i_rot_y,
    input  logic                 i_rot_done
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IDX_WIDTH:0] MAX_CNT  = (IDX_WIDTH+1)'(NUM_POINTS);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 2);

    seq_state_t           r_state, w_nxt_state;
    logic [IDX_WIDTH-1:0] r_idx, w_nxt_idx;
    logic [IDX_WIDTH:0]   r_cnt, w_nxt_cnt, w_clamp;
    logic [ANG_WIDTH-1:0] r_ang, w_nxt_ang;
    logic [TW-1:0]        r_tmo, w_nxt_tmo;
    logic                 r_err, w_nxt_err, w_res_we, w_act;
    logic [VEC_WIDTH-1:0] w_vx, w_vy;

    assign w_clamp = (i_count > MAX_CNT) ? MAX_CNT : i_count;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt;
        w_nxt_ang   = r_ang;
        w_nxt_tmo   = r_tmo;
        w_nxt_err   = r_err;
        w_res_we    = 1'b0;
        case (r_state)
            S_IDLE: if (i_go) begin
                w_nxt_ang   = i_angle;
                w_nxt_cnt   = w_clamp;
                w_nxt_idx   = '0;
                w_nxt_err   = 1'b0;
                w_nxt_state = (w_clamp == '0) ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: begin
                w_nxt_tmo   = '0;
                w_nxt_state = S_WAIT;
            end
            S_WAIT: if (i_rot_done) begin
                w_res_we = 1'b1;
                if ({1'b0, r_idx} == r_cnt - (IDX_WIDTH+1)'(1))
                    w_nxt_state = S_FINISH;
                else begin
                    w_nxt_idx   = r_idx + 1'b1;
                    w_nxt_state = S_ISSUE;
                end
            end else if (r_tmo == TMO_LAST) begin
                // the rotator never answered: abort the batch without a done pulse
                w_nxt_err   = 1'b1;
                w_nxt_state = S_IDLE;
            end else
                w_nxt_tmo = r_tmo + 1'b1;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_ang   <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
            r_ang   <= w_nxt_ang;
            r_tmo   <= w_nxt_tmo;
            r_err   <= w_nxt_err;
        end
    end

    point_bank #(.VEC_WIDTH(VEC_WIDTH), .NUM_POINTS(NUM_POINTS), .IDX_WIDTH(IDX_WIDTH)) u_vert (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en && !o_busy), .i_wr_idx(i_wr_idx),
        .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_rd_idx(r_idx), .o_rd_x(w_vx), .o_rd_y(w_vy)
    );

    point_bank #(.VEC_WIDTH(VEC_WIDTH), .NUM_POINTS(NUM_POINTS), .IDX_WIDTH(IDX_WIDTH)) u_res (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(w_res_we), .i_wr_idx(r_idx),
        .i_wr_x(i_rot_x), .i_wr_y(i_rot_y), .i_rd_idx(i_rd_idx), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y)
    );

    // operands stay stable through the done cycle since the vertex bank is write-locked while busy
    assign w_act       = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign o_busy      = r_state != S_IDLE;
    assign o_done      = r_state == S_FINISH;
    assign o_error     = r_err;
    assign o_rot_start = r_state == S_ISSUE;
    assign o_rot_x     = w_act ? w_vx : '0;
    assign o_rot_y     = w_act ? w_vy : '0;
    assign o_rot_angle = w_act ? r_ang : '0;
endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: directed checks of the sequencer against a behavioural quarter-turn rotator
module tb_rotate_sequencer;
    import rotate_seq_pkg::*;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_wr_en = 1'b0;
    logic [2:0]         i_wr_idx = '0;
    logic signed [6:0]  i_wr_x = '0, i_wr_y = '0;
    logic [3:0]         i_count = '0;
    logic signed [8:0]  i_angle = '0;
    logic               i_go = 1'b0;
    logic               o_busy, o_done, o_error, o_rot_start;
    logic [2:0]         i_rd_idx = '0;
    logic signed [6:0]  o_rd_x, o_rd_y, o_rot_x, o_rot_y, i_rot_x, i_rot_y;
    logic signed [8:0]  o_rot_angle;
    logic               i_rot_done;

    int n_chk = 0, n_fail = 0, cyc = 0, n_done = 0, n_start = 0, saved;
    logic               en_rot = 1'b1;
    logic [4:0]         m_cnt = '0;
    logic signed [6:0]  m_x = '0, m_y = '0;

    rotate_sequencer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx),
        .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_count(i_count), .i_angle(i_angle), .i_go(i_go),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .i_rd_idx(i_rd_idx),
        .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .o_rot_start(o_rot_start), .o_rot_x(o_rot_x),
        .o_rot_y(o_rot_y), .o_rot_angle(o_rot_angle), .i_rot_x(i_rot_x), .i_rot_y(i_rot_y),
        .i_rot_done(i_rot_done)
    );

    always #5 i_clk = ~i_clk;

    // rotator model: done ROT_LATENCY cycles after start, exact for quarter turns, live angle
    always @(posedge i_clk) begin
        if (o_rot_start) begin
            m_cnt <= 5'(ROT_LATENCY);
            m_x   <= o_rot_x;
            m_y   <= o_rot_y;
        end else if (m_cnt != 0)
            m_cnt <= m_cnt - 1'b1;
        if (o_done) n_done++;
        if (o_rot_start) n_start++;
    end
    assign i_rot_done = en_rot && (m_cnt == 5'd1);
    always_comb begin
        i_rot_x = m_x;
        i_rot_y = m_y;
        if (o_rot_angle == 9'sd90) begin i_rot_x = -m_y; i_rot_y = m_x; end
        else if (o_rot_angle == 9'sd180 || o_rot_angle == -9'sd180) begin i_rot_x = -m_x; i_rot_y = -m_y; end
        else if (o_rot_angle == -9'sd90) begin i_rot_x = m_y; i_rot_y = -m_x; end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input int idx, input int x, input int y);
        i_wr_en = 1'b1; i_wr_idx = 3'(idx); i_wr_x = 7'(x); i_wr_y = 7'(y);
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic go(input int n, input int a);
        i_go = 1'b1; i_count = 4'(n); i_angle = 9'(a);
        tick();
        i_go = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done();
        while (!o_done && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    task automatic rd_chk(input string tag, input int idx, input int ex, input int ey);
        i_rd_idx = 3'(idx);
        #1;
        chk({tag, ".x"}, o_rd_x, ex);
        chk({tag, ".y"}, o_rd_y, ey);
    endtask

    initial begin
        #3;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_error", o_error, 0);
        chk("rst_start", o_rot_start, 0);
        #9 i_rst_n = 1'b1;
        tick();

        // single point, 90 degrees
        wr(0, 50, 0);
        go(1, 90);
        chk("t1_start", o_rot_start, 1);
        chk("t1_rot_x", o_rot_x, 50);
        chk("t1_angle", o_rot_angle, 90);
        chk("t1_busy", o_busy, 1);
        wait_done();
        chk("t1_done_cycle", cyc, 15);
        rd_chk("t1_res0", 0, 0, 50);
        tick();
        chk("t1_done_pulse", o_done, 0);
        chk("t1_idle", o_busy, 0);

        // three points, 180 degrees, with ignored go/write while busy
        wr(1, 0, 50);
        wr(2, -30, 40);
        go(3, 180);
        repeat (4) begin tick(); cyc++; end
        i_go = 1'b1; i_count = 4'd1; i_wr_en = 1'b1; i_wr_idx = 3'd0; i_wr_x = 7'sd1; i_wr_y = 7'sd1;
        tick(); cyc++;
        i_go = 1'b0; i_wr_en = 1'b0;
        wait_done();
        chk("t2_done_cycle", cyc, 43);
        rd_chk("t2_res0", 0, -50, 0);
        rd_chk("t2_res1", 1, 0, -50);
        rd_chk("t2_res2", 2, 30, -40);
        tick();

        // vertex 0 must still be (50,0) after the ignored write
        go(1, 0);
        wait_done();
        chk("t3_done_cycle", cyc, 15);
        rd_chk("t3_res0", 0, 50, 0);
        tick();

        // zero count
        saved = n_start;
        go(0, 90);
        chk("t4_done_cycle1", o_done, 1);
        tick();
        chk("t4_no_start", n_start, saved);
        rd_chk("t4_res0_kept", 0, 50, 0);
        rd_chk("t4_res1_kept", 1, 0, -50);

        // count above depth clamps to NUM_POINTS
        go(15, -90);
        wait_done();
        chk("t5_done_cycle", cyc, 113);
        rd_chk("t5_res0", 0, 0, -50);
        rd_chk("t5_res2", 2, 40, 30);
        rd_chk("t5_res7", 7, 0, 0);
        tick();

        // rotator never answers
        en_rot = 1'b0;
        saved = n_done;
        go(2, 90);
        while (cyc < 32) begin tick(); cyc++; end
        chk("t6_busy_c32", o_busy, 1);
        chk("t6_err_c32", o_error, 0);
        tick(); cyc++;
        chk("t6_err_c33", o_error, 1);
        chk("t6_busy_c33", o_busy, 0);
        tick();
        chk("t6_no_done", n_done, saved);
        chk("t6_err_sticky", o_error, 1);
        en_rot = 1'b1;
        go(0, 0);
        chk("t6_err_clear", o_error, 0);
        chk("t6_done", o_done, 1);
        tick();

        // async reset mid-WAIT
        saved = n_done;
        go(1, 90);
        repeat (4) tick();
        #2 i_rst_n = 1'b0;
        #1;
        i_rd_idx = 3'd0;
        #1;
        chk("t7_busy", o_busy, 0);
        chk("t7_done", o_done, 0);
        chk("t7_start", o_rot_start, 0);
        chk("t7_rot_x", o_rot_x, 0);
        chk("t7_angle", o_rot_angle, 0);
        chk("t7_res0", o_rd_y, 0);
        #10 i_rst_n = 1'b1;
        repeat (20) tick();
        chk("t7_no_done", n_done, saved);
        chk("t7_idle", o_busy, 0);
        rd_chk("t7_res0_after", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
